ro_puf_ctrl: RTL and testbench
==============================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 SHALL have parameter CHAL_W, default 8, number of configurable stages per ring chain.
REQ-002 SHALL have parameter CNT_W, default 16, edge-counter width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, ring-enabled cycles before counting starts (>=1).
REQ-004 SHALL have parameter WINDOW_CYCLES, default 1024, counting-window length in clk cycles (>=1).
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request one evaluation; sampled only in IDLE.
REQ-008 SHALL have port chal, input, CHAL_W, challenge; captured when start is accepted.
REQ-009 SHALL have port abort, input, 1, cancel any evaluation in progress.
REQ-010 SHALL have port ro_a, input, 1, ring chain A output (asynchronous to clk).
REQ-011 SHALL have port ro_b, input, 1, ring chain B output (asynchronous to clk).
REQ-012 SHALL have port ro_en, output, 1, enables both ring chains.
REQ-013 SHALL have port cfg_sel, output, CHAL_W, per-stage sel drive for both chains (latched challenge).
REQ-014 SHALL have port cfg_bx, output, CHAL_W, per-stage bx drive (latched challenge, bit-reversed).
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port resp_valid, output, 1, response available.
REQ-017 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-018 SHALL have port resp, output, 1, response bit.
REQ-019 SHALL have port resp_tie, output, 1, counts were equal.
REQ-020 SHALL have ports cnt_a and cnt_b, output, CNT_W each, final edge counts.

Function
REQ-021 SHALL implement FSM states IDLE, SETTLE, COUNT, COMPARE, DONE.
REQ-022 IDLE: start=1 -> latch chal into cfg register, clear counters, go SETTLE; start=0 -> stay.
REQ-023 SETTLE: ro_en=1, counters held at 0; after SETTLE_CYCLES cycles -> COUNT.
REQ-024 COUNT: ro_en=1, counters enabled; after exactly WINDOW_CYCLES cycles -> COMPARE.
REQ-025 COMPARE: ro_en=0, counters frozen; one cycle; registers resp and resp_tie; -> DONE.
REQ-026 DONE: resp_valid=1, resp/resp_tie/cnt_a/cnt_b held stable; resp_ready=1 -> IDLE next cycle.
REQ-027 ro_a and ro_b SHALL each pass a 2-flop synchronizer, then a rising-edge detector; each detected edge in COUNT increments its counter by 1.
REQ-028 Counters SHALL saturate at 2^CNT_W-1; no wrap.
REQ-029 resp SHALL be 1 iff cnt_a > cnt_b; on equality resp=0 and resp_tie=1; otherwise resp_tie=0.
REQ-030 Latency: start accepted at edge k -> resp_valid first high after edge k+SETTLE_CYCLES+WINDOW_CYCLES+2.
REQ-031 ro_en SHALL be high only in SETTLE and COUNT; cfg_sel/cfg_bx SHALL change only on start acceptance.
REQ-032 start in any state other than IDLE SHALL be ignored; start in DONE is not queued.
REQ-033 abort=1 in SETTLE, COUNT or COMPARE -> IDLE next cycle, ro_en=0, no resp_valid; abort has priority over all transitions; abort in IDLE or DONE has no effect.
REQ-034 resp_valid and resp_ready both high SHALL be the only way to leave DONE.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, ro_en=0, busy=0, resp_valid=0, resp=0, resp_tie=0, cnt_a=0, cnt_b=0, cfg_sel=0, cfg_bx=0, synchronizer flops=0.
REQ-036 rst asserted mid-evaluation SHALL discard it; after release, only a new start begins an evaluation.

Verification
REQ-037 SETTLE=4, WINDOW=100, chal=8'hA5, ro_a toggling every 2 clk, ro_b every 3 clk -> cfg_sel=8'hA5, cfg_bx=8'hA5, cnt_a=25+/-1, cnt_b=17+/-1, resp=1, resp_valid after edge k+106.
REQ-038 Identical ro_a/ro_b stimulus -> cnt_a=cnt_b, resp=0, resp_tie=1.
REQ-039 resp_ready held low 50 cycles in DONE -> resp_valid and counts stable; start pulses ignored; resp_ready=1 -> IDLE next cycle.
REQ-040 abort in COUNT cycle 10 -> ro_en=0 and busy=0 next cycle, resp_valid never asserted.
REQ-041 CNT_W=4, ro_a toggling every clk, WINDOW=100 -> cnt_a=15 (saturated), resp=1.
REQ-042 rst pulsed asynchronously mid-COUNT -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: enables two configurable ring chains, counts their
// synchronized rising edges over a fixed window and reports which chain ran faster.
module ro_puf_ctrl #(
  parameter int CHAL_W        = 8,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal,
  input  logic              abort,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              ro_en,
  output logic [CHAL_W-1:0] cfg_sel,
  output logic [CHAL_W-1:0] cfg_bx,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp,
  output logic              resp_tie,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } StateT;

  StateT            state;
  StateT            nextState;
  logic [TMR_W-1:0] timer;
  logic             timerDone;
  logic             accept;
  logic             aSync1, aSync2, aPrev;
  logic             bSync1, bSync2, bPrev;
  logic             edgeA, edgeB;

  assign accept    = (state == IDLE) && start;
  assign timerDone = ((state == SETTLE) && (timer == SETTLE_LAST)) ||
                     ((state == COUNT)  && (timer == WINDOW_LAST));
  assign edgeA     = aSync2 & ~aPrev;
  assign edgeB     = bSync2 & ~bPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Abort outranks every other transition while an evaluation is running.
  always_comb begin
    nextState = state;
    ro_en     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nextState = SETTLE;
      end
      SETTLE: begin
        ro_en = 1'b1;
        if (abort)          nextState = IDLE;
        else if (timerDone) nextState = COUNT;
      end
      COUNT: begin
        ro_en = 1'b1;
        if (abort)          nextState = IDLE;
        else if (timerDone) nextState = COMPARE;
      end
      COMPARE: begin
        if (abort) nextState = IDLE;
        else       nextState = DONE;
      end
      DONE: begin
        if (resp_valid && resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Phase timer restarts on every state change so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      timer <= '0;
    else if (state != nextState)                  timer <= '0;
    else if ((state == SETTLE) || (state == COUNT)) timer <= timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSync1 <= 1'b0;
      aSync2 <= 1'b0;
      aPrev  <= 1'b0;
      bSync1 <= 1'b0;
      bSync2 <= 1'b0;
      bPrev  <= 1'b0;
    end else begin
      aSync1 <= ro_a;
      aSync2 <= aSync1;
      aPrev  <= aSync2;
      bSync1 <= ro_b;
      bSync2 <= bSync1;
      bPrev  <= bSync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_sel <= '0;
      cfg_bx  <= '0;
    end else if (accept) begin
      cfg_sel <= chal;
      for (int i = 0; i < CHAL_W; i++) cfg_bx[i] <= chal[CHAL_W-1-i];
    end
  end

  // Counters saturate instead of wrapping so a fast ring never looks slow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (accept) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == COUNT) begin
      if (edgeA && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
      if (edgeB && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp     <= 1'b0;
      resp_tie <= 1'b0;
    end else if ((state == COMPARE) && !abort) begin
      resp     <= (cnt_a > cnt_b);
      resp_tie <= (cnt_a == cnt_b);
    end
  end

  // Valid rises one cycle into DONE and drops on the accepting handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) resp_valid <= 1'b0;
    else     resp_valid <= (state == DONE) && !(resp_valid && resp_ready);
  end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: table rows plus random rows checked against an edge-counting
// model over logged ring samples, then hand-written DONE-hold, abort and reset sequences.
module tb_ro_puf_ctrl;

  localparam int S       = 4;
  localparam int W       = 100;
  localparam int SAT_MAX = 15;
  localparam int HIST    = 16384;

  typedef struct {
    logic [7:0] chal;
    int         halfA;
    int         halfB;
    bit         rndA;
    bit         rndB;
    bit         sameAB;
    logic [7:0] expSel;
    logic [7:0] expBx;
  } VecT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        roA = 1'b0;
  logic        roB = 1'b0;
  logic        respReady = 1'b0;
  logic [7:0]  chal = '0;

  logic        roEn, busy, respValid, resp, respTie;
  logic [7:0]  cfgSel, cfgBx;
  logic [15:0] cntA, cntB;

  logic        satRoEn, satBusy, satValid, satResp, satTie;
  logic [7:0]  satSel, satBx;
  logic [3:0]  satCntA, satCntB;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  logic histA [HIST];
  logic histB [HIST];

  int  halfA = 0, halfB = 0, phA = 0, phB = 0;
  bit  rndA = 0, rndB = 0, sameAB = 0;

  always #5 clk = ~clk;

  ro_puf_ctrl #(.CHAL_W(8), .CNT_W(16), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .start(start), .chal(chal), .abort(abort),
    .ro_a(roA), .ro_b(roB), .ro_en(roEn), .cfg_sel(cfgSel), .cfg_bx(cfgBx),
    .busy(busy), .resp_valid(respValid), .resp_ready(respReady), .resp(resp),
    .resp_tie(respTie), .cnt_a(cntA), .cnt_b(cntB)
  );

  ro_puf_ctrl #(.CHAL_W(8), .CNT_W(4), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dutSat (
    .clk(clk), .rst(rst), .start(start), .chal(chal), .abort(abort),
    .ro_a(roA), .ro_b(roB), .ro_en(satRoEn), .cfg_sel(satSel), .cfg_bx(satBx),
    .busy(satBusy), .resp_valid(satValid), .resp_ready(respReady), .resp(satResp),
    .resp_tie(satTie), .cnt_a(satCntA), .cnt_b(satCntB)
  );

  // Ring stimulus changes on the falling edge: square waves, random bits, or B copying A.
  initial forever begin
    @(negedge clk);
    if (rndA)            roA = ($urandom_range(0, 1) == 1);
    else if (halfA == 0) roA = 1'b0;
    else begin
      phA++;
      if (phA >= halfA) begin phA = 0; roA = ~roA; end
    end
    if (sameAB)          roB = roA;
    else if (rndB)       roB = ($urandom_range(0, 1) == 1);
    else if (halfB == 0) roB = 1'b0;
    else begin
      phB++;
      if (phB >= halfB) begin phB = 0; roB = ~roB; end
    end
  end

  // Sample log indexed by rising-edge number; at a falling edge cyc names the next edge.
  initial forever begin
    @(posedge clk);
    if (cyc < HIST) begin
      histA[cyc] = roA;
      histB[cyc] = roB;
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A ring edge reaches the counter after the two synchronizer flops plus the edge
  // detector, so counter edge e sees the ring rising between samples e-3 and e-2.
  function automatic int modelEdges(input int k, input bit chanB);
    int n;
    logic cur, prv;
    n = 0;
    for (int e = k + S + 1; e <= k + S + W; e++) begin
      cur = chanB ? histB[e-2] : histA[e-2];
      prv = chanB ? histB[e-3] : histA[e-3];
      if (cur && !prv) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] bitRev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic setStimulus(input VecT v);
    @(negedge clk);
    halfA = v.halfA; halfB = v.halfB;
    rndA = v.rndA; rndB = v.rndB; sameAB = v.sameAB;
    phA = 0; phB = 0; roA = 1'b0; roB = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic startEval(input logic [7:0] c, output int k);
    @(negedge clk);
    start = 1'b1;
    chal = c;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    chal = 8'($urandom);
  endtask

  task automatic waitValid(input int k);
    int n;
    n = 0;
    while (!respValid && n < S + W + 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_valid_seen", 32'(respValid), 1);
    // First high after edge k+S+W+2, seen at the falling edge where cyc = k+S+W+3.
    checkOutput("latency", 32'(cyc - k), S + W + 3);
  endtask

  task automatic applyStimulus(input VecT v);
    int k, ea, eb, sa, sb;
    setStimulus(v);
    startEval(v.chal, k);
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("ro_en_settle", 32'(roEn), 1);
    checkOutput("cfg_sel", 32'(cfgSel), 32'(v.expSel));
    checkOutput("cfg_bx", 32'(cfgBx), 32'(v.expBx));
    waitValid(k);
    ea = modelEdges(k, 1'b0);
    eb = modelEdges(k, 1'b1);
    checkOutput("cnt_a", 32'(cntA), ea);
    checkOutput("cnt_b", 32'(cntB), eb);
    checkOutput("resp", 32'(resp), 32'(ea > eb));
    checkOutput("resp_tie", 32'(respTie), 32'(ea == eb));
    checkOutput("ro_en_done", 32'(roEn), 0);
    checkOutput("cfg_sel_held", 32'(cfgSel), 32'(v.expSel));
    sa = (ea > SAT_MAX) ? SAT_MAX : ea;
    sb = (eb > SAT_MAX) ? SAT_MAX : eb;
    checkOutput("sat_valid", 32'(satValid), 1);
    checkOutput("sat_cnt_a", 32'(satCntA), sa);
    checkOutput("sat_cnt_b", 32'(satCntB), sb);
    checkOutput("sat_resp", 32'(satResp), 32'(sa > sb));
    checkOutput("sat_tie", 32'(satTie), 32'(sa == sb));
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checkOutput("busy_after_ack", 32'(busy), 0);
    checkOutput("valid_after_ack", 32'(respValid), 0);
  endtask

  VecT vecs[$];
  VecT rv;
  int  k, ea, eb;
  bit  sawValid;

  initial begin
    vecs.push_back('{8'hA5, 2, 3, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5});
    vecs.push_back('{8'h01, 3, 2, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80});
    vecs.push_back('{8'hF0, 2, 0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F});
    vecs.push_back('{8'h3C, 0, 0, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C});
    vecs.push_back('{8'h12, 0, 0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h48});
    vecs.push_back('{8'hC3, 1, 0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3});
    vecs.push_back('{8'h6B, 0, 0, 1'b0, 1'b0, 1'b0, 8'h6B, 8'hD6});
    for (int i = 0; i < 4; i++) begin
      rv.chal   = 8'($urandom);
      rv.halfA  = int'($urandom_range(1, 5));
      rv.halfB  = int'($urandom_range(1, 5));
      rv.rndA   = $urandom_range(0, 1) == 1;
      rv.rndB   = $urandom_range(0, 1) == 1;
      rv.sameAB = 1'b0;
      rv.expSel = rv.chal;
      rv.expBx  = bitRev(rv.chal);
      vecs.push_back(rv);
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_ro_en", 32'(roEn), 0);
    checkOutput("reset_valid", 32'(respValid), 0);
    checkOutput("reset_cnt_a", 32'(cntA), 0);
    checkOutput("reset_cfg_bx", 32'(cfgBx), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Response held in DONE while the consumer stalls; start and abort must not disturb it.
    setStimulus(vecs[0]);
    startEval(8'h5A, k);
    waitValid(k);
    ea = modelEdges(k, 1'b0);
    eb = modelEdges(k, 1'b1);
    for (int i = 0; i < 50; i++) begin
      start = (i % 10 == 5);
      abort = (i == 23);
      @(negedge clk);
      checkOutput("hold_valid", 32'(respValid), 1);
      checkOutput("hold_cnt_a", 32'(cntA), ea);
      checkOutput("hold_cnt_b", 32'(cntB), eb);
      checkOutput("hold_resp", 32'(resp), 32'(ea > eb));
    end
    start = 1'b0;
    abort = 1'b0;
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checkOutput("hold_release_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    checkOutput("start_not_queued", 32'(busy), 0);

    // Abort during the tenth counting cycle.
    startEval(8'h77, k);
    while (cyc < k + S + 10) @(negedge clk);
    checkOutput("abort_pre_ro_en", 32'(roEn), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_ro_en", 32'(roEn), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    sawValid = 1'b0;
    repeat (S + W + 20) begin
      @(negedge clk);
      sawValid = sawValid | respValid;
    end
    checkOutput("abort_no_valid", 32'(sawValid), 0);

    // Asynchronous reset in the middle of counting.
    startEval(8'hE1, k);
    repeat (S + 40) @(negedge clk);
    checkOutput("pre_reset_ro_en", 32'(roEn), 1);
    checkOutput("pre_reset_cnt_nonzero", 32'(cntA != 16'd0), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_ro_en", 32'(roEn), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_valid", 32'(respValid), 0);
    checkOutput("async_resp", 32'(resp), 0);
    checkOutput("async_tie", 32'(respTie), 0);
    checkOutput("async_cnt_a", 32'(cntA), 0);
    checkOutput("async_cnt_b", 32'(cntB), 0);
    checkOutput("async_cfg_sel", 32'(cfgSel), 0);
    checkOutput("async_cfg_bx", 32'(cfgBx), 0);
    checkOutput("async_sat_busy", 32'(satBusy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_idle", 32'(busy), 0);
    applyStimulus(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
